// File: rtl/noc_out_arbiter.sv
// Round-robin output-port arbiter for a NoC router: grants one requester for a whole
// packet, registers the outgoing flit, and force-releases a stalled packet owner.
//
// state | meaning
// IDLE  | no owner; pick the next valid requester starting at ptr
// LOCK  | grant held by gidx until its tail flit transfers or the idle timeout fires
module noc_out_arbiter #(
   parameter int NPORT   = 5,
   parameter int FLIT_W  = 64,
   parameter int TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NPORT-1:0]        req_valid,
   input  logic [NPORT*FLIT_W-1:0] req_flit,
   input  logic [NPORT-1:0]        req_last,
   output logic [NPORT-1:0]        req_ready,
   output logic                    out_valid,
   output logic [FLIT_W-1:0]       out_flit,
   output logic                    out_last,
   input  logic                    out_ready,
   output logic [NPORT-1:0]        grant,
   output logic                    timeout_err
);

   localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     ptr, ptr_nxt;
   logic [PW-1:0]     gidx, gidx_nxt;
   logic [NPORT-1:0]  grant_nxt;
   logic [CW-1:0]     idle_cnt, idle_cnt_nxt;
   logic [PW-1:0]     sel_idx;
   logic              sel_found;
   logic              out_free;
   logic              gvalid, glast, xfer, tout_hit;
   logic [FLIT_W-1:0] flit_arr [NPORT];
   logic [PW-1:0]     rot_idx  [NPORT];
   logic [PW:0]       rot_sum  [NPORT];

   function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] v);
      if (v == PW'(NPORT - 1))
         return '0;
      return v + 1'b1;
   endfunction

   // rot_idx[i] = (ptr + i) mod NPORT; ptr < NPORT so one conditional subtract suffices
   for (genvar i = 0; i < NPORT; i++) begin : g_port
      assign flit_arr[i] = req_flit[i*FLIT_W +: FLIT_W];
      assign rot_sum[i]  = {1'b0, ptr} + (PW+1)'(i);
      assign rot_idx[i]  = (rot_sum[i] >= (PW+1)'(NPORT)) ?
                           PW'(rot_sum[i] - (PW+1)'(NPORT)) : PW'(rot_sum[i]);
   end

   // Walk from the farthest offset down so the nearest valid requester wins.
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int i = NPORT - 1; i >= 0; i--) begin
         if (req_valid[rot_idx[i]]) begin
            sel_idx   = rot_idx[i];
            sel_found = 1'b1;
         end
      end
   end

   assign out_free = ~out_valid | out_ready;
   assign gvalid   = req_valid[gidx];
   assign glast    = req_last[gidx];
   assign xfer     = (state == LOCK) && gvalid && out_free;

   always_comb begin
      req_ready = '0;
      if (state == LOCK)
         req_ready = grant & {NPORT{out_free}};
   end

   always_comb begin
      state_nxt    = state;
      ptr_nxt      = ptr;
      gidx_nxt     = gidx;
      grant_nxt    = grant;
      idle_cnt_nxt = idle_cnt;
      tout_hit     = 1'b0;
      case (state)
         IDLE: begin
            if (sel_found) begin
               state_nxt    = LOCK;
               gidx_nxt     = sel_idx;
               grant_nxt    = {{(NPORT-1){1'b0}}, 1'b1} << sel_idx;
               idle_cnt_nxt = '0;
            end
         end
         LOCK: begin
            if (xfer) begin
               idle_cnt_nxt = '0;
               if (glast) begin
                  state_nxt = IDLE;
                  grant_nxt = '0;
                  ptr_nxt   = inc_mod(gidx);
               end
            end else if (!gvalid) begin
               if (idle_cnt == CW'(TIMEOUT - 1)) begin
                  tout_hit     = 1'b1;
                  state_nxt    = IDLE;
                  grant_nxt    = '0;
                  ptr_nxt      = inc_mod(gidx);
                  idle_cnt_nxt = '0;
               end else begin
                  idle_cnt_nxt = idle_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         gidx     <= '0;
         grant    <= '0;
         idle_cnt <= '0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         gidx     <= gidx_nxt;
         grant    <= grant_nxt;
         idle_cnt <= idle_cnt_nxt;
      end
   end

   // Output register: a new transfer overwrites a flit only when it is being consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_flit    <= '0;
         out_last    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_flit  <= flit_arr[gidx];
            out_last  <= glast;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (tout_hit)
            timeout_err <= 1'b1;
      end
   end

endmodule
